// File: rtl/adc_spi_rx_pkg.sv
// Shared types and defaults for the ADC SPI receive front-end.
// Holds the FSM state encoding, mid-scale constant and default frame geometry.
package adc_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        QUIET = 2'd2
    } state_e;

    localparam int MIDSCALE        = 2048;
    localparam int FRAME_BITS_DEF  = 16;
    localparam int DATA_BITS_DEF   = 12;
    localparam int QUIET_EDGES_DEF = 2;

endpackage

// File: rtl/adc_spi_rx_if.sv
// Sample bus between the ADC receiver and the level meter.
// start: conversion request; busy/sample/sample_valid: receiver status and result.
interface adc_spi_rx_if #(
    parameter int DW = adc_spi_pkg::DATA_BITS_DEF
) ();

    logic          start;
    logic          busy;
    logic [DW-1:0] sample;
    logic          sample_valid;

    modport master (
        output start,
        input  busy,
        input  sample,
        input  sample_valid
    );

    modport slave (
        input  start,
        output busy,
        output sample,
        output sample_valid
    );

endinterface

// File: rtl/adc_spi_rx_edge_det.sv
// Registers a slow clock-like input in the clk_in domain and flags its edges.
// Ports: clk_in, reset (async, high), d_i in; rise_o/fall_o single-cycle flags.
module edge_det (
    input  logic clk_in,
    input  logic reset,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic d_q;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;
    assign fall_o = ~d_i & d_q;

endmodule

// File: rtl/adc_spi_rx.sv
// SPI receive front-end for a 12-bit ADCS7476-style converter.
// Ports: clk_in, reset (async, high), sclk_in, miso in; cs_n out; bus = sample bus slave.
// Build option ADC_SPI_RX_ABS_EN: sample is |raw - MIDSCALE| saturated to MIDSCALE-1.
module adc_spi_rx
    import adc_spi_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int DATA_BITS   = DATA_BITS_DEF,
    parameter int QUIET_EDGES = QUIET_EDGES_DEF,
    parameter int CNT_W       = 5
) (
    input  logic         clk_in,
    input  logic         reset,
    input  logic         sclk_in,
    input  logic         miso,
    output logic         cs_n,
    adc_spi_rx_if.slave  bus
);

    logic rise;
    logic fall;

    edge_det u_sclk_edge (
        .clk_in (clk_in),
        .reset  (reset),
        .d_i    (sclk_in),
        .rise_o (rise),
        .fall_o (fall)
    );

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    // Only the bits that can reach the sample are kept; the
    // leading zeros of the frame simply fall off the top.
    logic [DATA_BITS-2:0]   shift_q;
    logic                   pend_q;
    logic                   cs_n_q;
    logic                   valid_q;
    logic [DATA_BITS-1:0]   sample_q;

    logic [DATA_BITS-1:0]   raw_d;
    logic [DATA_BITS-1:0]   sample_d;

    assign raw_d = {shift_q, miso};

`ifdef ADC_SPI_RX_ABS_EN
    logic signed [DATA_BITS:0] diff_d;
    logic        [DATA_BITS:0] mag_d;

    always_comb begin
        diff_d   = $signed({1'b0, raw_d})
                 - $signed((DATA_BITS+1)'(MIDSCALE));
        mag_d    = diff_d[DATA_BITS] ? $unsigned(-diff_d)
                                     : $unsigned(diff_d);
        sample_d = mag_d[DATA_BITS-1:0];
        // Full-scale negative (code 0) is one past the positive range.
        if (mag_d > (DATA_BITS+1)'(MIDSCALE - 1)) begin
            sample_d = DATA_BITS'(MIDSCALE - 1);
        end
    end
`else
    assign sample_d = raw_d;
`endif

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            pend_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            valid_q  <= 1'b0;
            sample_q <= '0;
        end else begin
            valid_q <= 1'b0;
            if (bus.start) begin
                pend_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    // Launch on a falling SCLK so the ADC sees a
                    // full low phase before the first rising edge.
                    if (pend_q && fall) begin
                        cs_n_q  <= 1'b0;
                        cnt_q   <= '0;
                        pend_q  <= bus.start;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    if (rise) begin
                        if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                            cs_n_q   <= 1'b1;
                            sample_q <= sample_d;
                            valid_q  <= 1'b1;
                            cnt_q    <= '0;
                            state_q  <= QUIET;
                        end else begin
                            shift_q <= raw_d[DATA_BITS-2:0];
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                QUIET: begin
                    if (rise) begin
                        if (cnt_q == CNT_W'(QUIET_EDGES - 1)) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cs_n             = cs_n_q;
    assign bus.busy         = (state_q != IDLE) | pend_q;
    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;

endmodule

// File: tb/tb_adc_spi_rx.sv
// Self-checking bench for adc_spi_rx with an ADC model and a divided SCLK.
// Honours ADC_SPI_RX_ABS_EN in its reference model.
module tb_adc_spi_rx;

    logic clk_in  = 1'b0;
    logic reset   = 1'b1;
    logic sclk_in = 1'b0;
    logic miso    = 1'b0;
    logic sclk_en = 1'b1;
    logic cs_n;

    adc_spi_rx_if bus ();

    adc_spi_rx dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .sclk_in (sclk_in),
        .miso    (miso),
        .cs_n    (cs_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] adc_q[$];
    logic [11:0] got_q[$];

    int   vcount     = 0;
    int   frames     = 0;
    int   low_rises  = 0;
    int   hi_rises   = 0;
    int   last_quiet = 0;
    int   busy_low   = 0;
    int   dbl        = 0;
    int   vrises     = 0;
    logic vcs        = 1'b0;
    logic vprevcs    = 1'b0;
    logic prev_cs    = 1'b1;
    logic prev_sclk  = 1'b0;
    logic prev_valid = 1'b0;

    initial forever #5 clk_in = ~clk_in;

    // Clock divider stand-in: SCLK period of 8 clk_in cycles.
    initial begin
        int div;
        div = 0;
        forever begin
            @(posedge clk_in);
            #2;
            if (sclk_en) begin
                div++;
                if (div == 4) begin
                    div = 0;
                    sclk_in = ~sclk_in;
                end
            end
        end
    end

    // ADC: first bit on CS fall, next bits after each SCLK fall.
    initial begin
        logic [15:0] w;
        forever begin
            @(negedge cs_n);
            w = (adc_q.size() != 0) ? adc_q.pop_front() : 16'h0;
            miso = w[15];
            for (int i = 14; i >= 0; i--) begin
                @(negedge sclk_in or posedge cs_n);
                if (cs_n) break;
                miso = w[i];
            end
        end
    end

    // Passive observer of the pins and the sample bus.
    initial forever begin
        @(negedge clk_in);
        if (prev_cs && !cs_n) begin
            frames++;
            last_quiet = hi_rises;
            low_rises  = 0;
        end
        if (!prev_cs && cs_n) hi_rises = 0;
        if (sclk_in && !prev_sclk) begin
            if (!cs_n) low_rises++;
            else       hi_rises++;
        end
        if (!bus.busy) busy_low++;
        if (bus.sample_valid) begin
            vcount++;
            got_q.push_back(bus.sample);
            vcs     = cs_n;
            vprevcs = prev_cs;
            vrises  = low_rises;
            if (prev_valid) dbl++;
        end
        prev_cs    = cs_n;
        prev_sclk  = sclk_in;
        prev_valid = bus.sample_valid;
    end

    function automatic logic [11:0] ref_sample(input logic [15:0] w);
        int v;
        int m;
        v = int'(w[11:0]);
        m = v;
`ifdef ADC_SPI_RX_ABS_EN
        m = (v >= 2048) ? v - 2048 : 2048 - v;
        if (m > 2047) m = 2047;
`endif
        return 12'(m);
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [11:0] exp);
        logic [11:0] g;
        if (got_q.size() == 0) begin
            check({tag, "_missing"}, 32'd0, 32'd1);
        end else begin
            g = got_q.pop_front();
            check(tag, {20'd0, g}, {20'd0, exp});
        end
    endtask

    task automatic wait_launch(input int bf);
        for (int k = 0; k < 400 && frames == bf; k++) tick();
        check("launch", frames - bf, 1);
    endtask

    task automatic wait_low_rises(input int n);
        for (int k = 0; k < 400 && low_rises < n; k++) tick();
        check("rise_wait", 32'(low_rises >= n), 32'd1);
    endtask

    task automatic run_frame(input logic [15:0] w, input string tag);
        int bv;
        bv = vcount;
        adc_q.push_back(w);
        pulse_start();
        check({tag, "_busy"}, bus.busy, 1);
        for (int k = 0; k < 600 && vcount == bv; k++) tick();
        check({tag, "_vld"}, vcount - bv, 1);
        pop_check(tag, ref_sample(w));
        check({tag, "_cs_at_vld"}, vcs, 1);
        check({tag, "_cs_before"}, vprevcs, 0);
        check({tag, "_rises"}, vrises, 16);
        check({tag, "_single"}, dbl, 0);
        for (int k = 0; k < 200 && bus.busy; k++) tick();
        check({tag, "_idle"}, bus.busy, 0);
        check({tag, "_held"}, bus.sample, ref_sample(w));
    endtask

    initial begin
        int bf;
        int bv;
        int b0;
        int lr;
        logic [15:0] w1;
        logic [15:0] w2;

        bus.start = 1'b0;
        repeat (3) tick();
        check("rst_cs_n", cs_n, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_sample", bus.sample, 0);
        check("rst_valid", bus.sample_valid, 0);
        reset = 1'b0;

        repeat (160) tick();
        check("idle_cs_n", cs_n, 1);
        check("idle_busy", bus.busy, 0);
        check("idle_vld", vcount, 0);
        check("idle_frames", frames, 0);

        run_frame(16'h0A53, "a53");
        for (int i = 0; i < 4; i++) begin
            run_frame({4'h0, 12'($urandom)}, "rnd");
        end

        // Three starts during one frame give exactly one more frame.
        w1 = {4'h0, 12'($urandom)};
        w2 = {4'h0, 12'($urandom)};
        bf = frames;
        bv = vcount;
        adc_q.push_back(w1);
        adc_q.push_back(w2);
        pulse_start();
        check("ms_busy0", bus.busy, 1);
        b0 = busy_low;
        wait_launch(bf);
        wait_low_rises(3);
        repeat (3) begin
            pulse_start();
            repeat (5) tick();
        end
        for (int k = 0; k < 1200 && vcount < bv + 2; k++) tick();
        check("ms_vld", vcount - bv, 2);
        check("ms_frames", frames - bf, 2);
        check("ms_busy_held", busy_low - b0, 0);
        check("ms_quiet", 32'(last_quiet >= 2), 1);
        pop_check("ms_s1", ref_sample(w1));
        pop_check("ms_s2", ref_sample(w2));
        for (int k = 0; k < 200 && bus.busy; k++) tick();
        repeat (200) tick();
        check("ms_no_more", frames - bf, 2);

        // Reset mid-frame after the 7th rise.
        bf = frames;
        adc_q.push_back({4'h0, 12'($urandom)});
        pulse_start();
        wait_launch(bf);
        wait_low_rises(7);
        bv = vcount;
        reset = 1'b1;
        #1;
        check("mr_cs_n", cs_n, 1);
        check("mr_sample", bus.sample, 0);
        check("mr_valid", bus.sample_valid, 0);
        check("mr_busy", bus.busy, 0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (100) tick();
        check("mr_no_vld", vcount - bv, 0);
        check("mr_cs_idle", cs_n, 1);
        run_frame({4'h0, 12'($urandom)}, "after_rst");

        // SCLK stalls mid-frame then resumes.
        w1 = {4'h0, 12'($urandom)};
        bf = frames;
        adc_q.push_back(w1);
        pulse_start();
        wait_launch(bf);
        wait_low_rises(5);
        sclk_en = 1'b0;
        lr = low_rises;
        bv = vcount;
        repeat (50) tick();
        check("st_cs_n", cs_n, 0);
        check("st_rises", low_rises, lr);
        check("st_no_vld", vcount - bv, 0);
        check("st_busy", bus.busy, 1);
        sclk_en = 1'b1;
        for (int k = 0; k < 600 && vcount == bv; k++) tick();
        check("st_vld", vcount - bv, 1);
        check("st_rises_tot", vrises, 16);
        pop_check("st_sample", ref_sample(w1));

        // Codes at the ends and middle of the range.
        run_frame(16'h0FFF, "fff");
        run_frame(16'h0000, "zero");
        run_frame(16'h0800, "mid");
        run_frame(16'h07FF, "mid_m1");

        check("no_double", dbl, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
